// File: rtl/updown_count_checker.sv
// updown_count_checker: passive monitor that predicts the next value of an up/down counter
// and reports mismatches. Define UPDOWN_CHK_FIRST_ERR_EN to capture the first mismatch seen.
//
// state  | meaning
// IDLE   | no history yet; capture the first sample, no comparison
// ARMED  | comparing; counting consecutive matches toward lock, no errors reported
// LOCKED | checking; every mismatch is reported and counted
module updown_count_checker #(
  parameter int WIDTH       = 4,
  parameter int LOCK_CYCLES = 4,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dut_rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     count,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 wrap_pulse,
  output logic [WIDTH-1:0]     first_exp,
  output logic [WIDTH-1:0]     first_act
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CYCLES);

  state_t             state, state_nxt;
  logic [3:0]         match_cnt, match_cnt_nxt;
  logic               prev_dut_rst, prev_en, prev_mode;
  logic [WIDTH-1:0]   prev_count, predicted;
  logic               match, mismatch_err, wrap_det;

  always_comb begin
    predicted = prev_count;
    if (prev_dut_rst)   predicted = '0;
    else if (!prev_en)  predicted = prev_count;
    else if (prev_mode) predicted = prev_count + WIDTH'(1);
    else                predicted = prev_count - WIDTH'(1);
  end

  assign match = (count == predicted);

  assign wrap_det = (state != IDLE) && match && prev_en && !prev_dut_rst &&
                    (((prev_count == CNT_MAX) && (count == '0)) ||
                     ((prev_count == '0) && (count == CNT_MAX)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    match_cnt_nxt = match_cnt;
    mismatch_err  = 1'b0;
    case (state)
      IDLE: begin
        state_nxt     = ARMED;
        match_cnt_nxt = '0;
      end
      ARMED: begin
        if (match) begin
          match_cnt_nxt = match_cnt + 4'd1;
          if ((match_cnt + 4'd1) == LOCK_TGT) begin
            state_nxt     = LOCKED;
            match_cnt_nxt = '0;
          end
        end else begin
          match_cnt_nxt = '0;
        end
      end
      LOCKED: mismatch_err = !match;
      default: begin
        state_nxt     = IDLE;
        match_cnt_nxt = '0;
      end
    endcase
    // clear overrides everything, including an error seen on the same cycle
    if (clear) begin
      state_nxt     = IDLE;
      match_cnt_nxt = '0;
      mismatch_err  = 1'b0;
    end
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt    <= '0;
      prev_dut_rst <= 1'b0;
      prev_en      <= 1'b0;
      prev_mode    <= 1'b0;
      prev_count   <= '0;
      err_pulse    <= 1'b0;
      wrap_pulse   <= 1'b0;
      err_count    <= '0;
    end else begin
      match_cnt    <= match_cnt_nxt;
      prev_dut_rst <= dut_rst;
      prev_en      <= en;
      prev_mode    <= mode;
      prev_count   <= count;
      err_pulse    <= mismatch_err;
      wrap_pulse   <= wrap_det;
      if (clear)
        err_count <= '0;
      else if (mismatch_err && (err_count != '1))
        err_count <= err_count + ERR_CNT_W'(1);
    end
  end

`ifdef UPDOWN_CHK_FIRST_ERR_EN
  logic first_seen;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_seen <= 1'b0;
      first_exp  <= '0;
      first_act  <= '0;
    end else if (clear) begin
      first_seen <= 1'b0;
      first_exp  <= '0;
      first_act  <= '0;
    end else if (mismatch_err && !first_seen) begin
      first_seen <= 1'b1;
      first_exp  <= predicted;
      first_act  <= count;
    end
  end
`else
  assign first_exp = '0;
  assign first_act = '0;
`endif

endmodule
